// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch types, instruction width and default reset PC
package fetch_stage_pkg;
  localparam int INSTR_W = 32;
  typedef logic [31:0] pc_t;
  typedef struct packed {
    pc_t  pcnext;
    logic taken;
  } bp_t;
  typedef struct packed {
    pc_t                pc;
    bp_t                pred;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
  localparam pc_t RESET_PC_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/fetch_stage_queue.sv
// fetch_queue: in-order fetch buffer with alloc/fill/head pointers, filled bits and flush
module fetch_queue import fetch_stage_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               alloc,
  input  pc_t                alloc_pc,
  input  bp_t                alloc_pred,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               deq,
  output logic [PW-1:0]      alloc_cnt,
  output logic [PW-1:0]      unfilled,
  output logic               head_filled,
  output fq_entry_t          head
);
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, head_ptr_q, head_ptr_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  fq_entry_t ent_q [DEPTH];
  fq_entry_t ent_d [DEPTH];
  always_comb begin
    alloc_ptr_d = flush ? '0 : alloc_ptr_q + PW'(alloc);
    fill_ptr_d = flush ? '0 : fill_ptr_q + PW'(fill);
    head_ptr_d = flush ? '0 : head_ptr_q + PW'(deq);
    ent_d = ent_q;
    filled_d = filled_q;
    if (alloc) begin
      ent_d[alloc_ptr_q[AW-1:0]].pc = alloc_pc;
      ent_d[alloc_ptr_q[AW-1:0]].pred = alloc_pred;
      filled_d[alloc_ptr_q[AW-1:0]] = 1'b0;
    end
    if (fill) begin
      ent_d[fill_ptr_q[AW-1:0]].instr = fill_instr;
      filled_d[fill_ptr_q[AW-1:0]] = 1'b1;
    end
    if (flush) filled_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      alloc_ptr_q <= '0;
      fill_ptr_q <= '0;
      head_ptr_q <= '0;
      filled_q <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      head_ptr_q <= head_ptr_d;
      filled_q <= filled_d;
    end
    ent_q <= ent_d;
  end
  assign alloc_cnt = alloc_ptr_q - head_ptr_q;
  assign unfilled = alloc_ptr_q - fill_ptr_q;
  assign head = ent_q[head_ptr_q[AW-1:0]];
  assign head_filled = filled_q[head_ptr_q[AW-1:0]];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC owner issuing predicted-path imem requests into a flushable fetch queue
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int  FQ_DEPTH = 4,
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               redirect_valid,
  input  pc_t                redirect_pc,
  output logic               bp_valid,
  output logic               bp_ready,
  output pc_t                bp_pc,
  input  bp_t                bp_pred,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output pc_t                imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output pc_t                dec_pc,
  output logic [INSTR_W-1:0] dec_instr,
  output bp_t                dec_pred
);
  localparam int PW = $clog2(FQ_DEPTH) + 1;
  localparam logic [PW:0] FQ_LIMIT = (PW+1)'(FQ_DEPTH);
  logic [PW-1:0] alloc_cnt, unfilled, unfilled_after, drop_cnt_q, drop_cnt_d, drop_after;
  logic [PW:0] credit_used;
  pc_t pc_q, pc_d;
  logic fire, fill, drop, deq, head_filled;
  fq_entry_t head;
  always_comb begin
    credit_used = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
    imem_req_valid = !redirect_valid && credit_used < FQ_LIMIT;
    fire = imem_req_valid && imem_req_ready;
    drop = imem_rsp_valid && drop_cnt_q != '0;
    fill = imem_rsp_valid && drop_cnt_q == '0;
    drop_after = drop_cnt_q - PW'(drop);
    unfilled_after = unfilled - PW'(fill);
    drop_cnt_d = redirect_valid ? drop_after + unfilled_after : drop_after;
    pc_d = redirect_valid ? redirect_pc : fire ? bp_pred.pcnext : pc_q;
    dec_valid = alloc_cnt != '0 && head_filled && !redirect_valid;
    deq = dec_valid && dec_ready;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (redirect_valid),
    .alloc       (fire),
    .alloc_pc    (pc_q),
    .alloc_pred  (bp_pred),
    .fill        (fill),
    .fill_instr  (imem_rsp_data),
    .deq         (deq),
    .alloc_cnt   (alloc_cnt),
    .unfilled    (unfilled),
    .head_filled (head_filled),
    .head        (head)
  );
  assign bp_valid = imem_req_valid;
  assign bp_ready = fire;
  assign bp_pc = pc_q;
  assign imem_req_addr = pc_q;
  assign dec_pc = head.pc;
  assign dec_instr = head.instr;
  assign dec_pred = head.pred;
  assert property (@(posedge clk) disable iff (!rstn) !(imem_rsp_valid && unfilled == '0 && drop_cnt_q == '0));
endmodule
